// File: rtl/aes_sbox_pkg.sv
// Shared definitions for the byte-serial AES SubBytes stage: sizes, FSM
// state names, a byte picker and a combinational AES S-box built from
// GF(2^8) inversion followed by the affine transform.
package aes_sbox_pkg;

    localparam int AES_BYTES = 16;
    localparam int BYTE_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } sb_state_e;

    // Byte idx of a 128-bit AES state, byte 0 in the least significant bits.
    function automatic logic [7:0] byte_of(input logic [127:0] state, input int idx);
        return state[idx*BYTE_W +: BYTE_W];
    endfunction

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] y;
        r = 8'h01;
        y = x;
        for (int i = 0; i < 7; i++) begin
            y = gf_mul(y, y);
            r = gf_mul(r, y);
        end
        return r;
    endfunction

    // AES forward S-box: inversion then affine transform with constant 0x63.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_subbytes_serial_if.sv
// Upstream/downstream valid-ready bus of the SubBytes stage. The master
// side is whoever supplies states and consumes results; the slave is the stage.
interface aes_subbytes_serial_if;
    import aes_sbox_pkg::*;

    logic                        in_valid;
    logic                        in_ready;
    logic [AES_BYTES*BYTE_W-1:0] in_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [AES_BYTES*BYTE_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/aes_sbox_lane.sv
// One S-box lane: input gating (zero or hold-last when inactive), the
// combinational S-box, and an optional output register for glitch isolation.
module aes_sbox_lane
    import aes_sbox_pkg::*;
#(
    parameter int SBOX_OUT_REG = 0,
    parameter int ZERO_IDLE    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_active,
    input  logic [7:0] i_byte,
    output logic [7:0] o_laneIn,
    output logic [7:0] o_sbox
);

    logic [7:0] r_last;
    logic [7:0] r_out;
    logic [7:0] w_in;
    logic [7:0] w_sbox;

    assign w_in     = i_active ? i_byte : ((ZERO_IDLE != 0) ? 8'h00 : r_last);
    assign w_sbox   = sbox(w_in);
    assign o_laneIn = w_in;
    assign o_sbox   = (SBOX_OUT_REG != 0) ? r_out : w_sbox;

    // Remember the last fed byte so the lane can hold it when ZERO_IDLE is off.
    always_ff @(posedge clk) begin
        if (rst)           r_last <= 8'h00;
        else if (i_active) r_last <= i_byte;
    end

    // Optional pipeline register between the S-box and the write-back.
    always_ff @(posedge clk) begin
        if (rst) r_out <= 8'h00;
        else     r_out <= w_sbox;
    end

endmodule

// File: rtl/aes_subbytes_serial.sv
// Byte-serial AES SubBytes: loads one 128-bit state, streams LANES bytes per
// cycle through the S-box lanes, writes results back in place, then presents
// the substituted state and zeroizes it once it has been taken.
module aes_subbytes_serial
    import aes_sbox_pkg::*;
#(
    parameter int LANES        = 1,
    parameter int SBOX_OUT_REG = 0,
    parameter int ZERO_IDLE    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_subbytes_serial_if.slave bus,
    output logic [3:0]           dbg_byte_idx
);

    localparam int N     = AES_BYTES / LANES;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int ST_W  = AES_BYTES * BYTE_W;

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_SUB  = 2'(SUB);
    localparam logic [1:0] ST_DONE = 2'(DONE);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_badLanes
        $error("aes_subbytes_serial: LANES must be 1, 2, 4, 8 or 16");
    end

    logic [1:0]         r_fsm;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_feed;
    logic               r_wbPend;
    logic [3:0]         r_wbBase;
    logic [ST_W-1:0]    r_state;

    logic               w_feed;
    logic               w_last;
    logic [3:0]         w_base;
    logic               w_wbEn;
    logic [3:0]         w_wbBase;
    logic [ST_W-1:0]    w_byteMask;
    logic [ST_W-1:0]    w_wbData;
    logic [LANES*8-1:0] w_laneIn;
    logic [LANES*8-1:0] w_laneOut;

    assign w_feed = (r_fsm == ST_SUB) && r_feed;
    assign w_last = (int'(r_cnt) == N - 1);
    assign w_base = 4'(int'(r_cnt) * LANES);

    assign bus.in_ready  = (r_fsm == ST_IDLE);
    assign bus.out_valid = (r_fsm == ST_DONE);
    assign bus.out_data  = (r_fsm == ST_DONE) ? r_state : '0;
    assign dbg_byte_idx  = w_feed ? w_base : 4'd0;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        aes_sbox_lane #(
            .SBOX_OUT_REG (SBOX_OUT_REG),
            .ZERO_IDLE    (ZERO_IDLE)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .i_active (w_feed),
            .i_byte   (byte_of(r_state, int'(w_base) + k)),
            .o_laneIn (w_laneIn[k*8 +: 8]),
            .o_sbox   (w_laneOut[k*8 +: 8])
        );
    end

    // Decode which bytes of the state register are overwritten this cycle;
    // with the output register the write-back trails the feed by one cycle.
    always_comb begin
        w_wbEn     = (SBOX_OUT_REG != 0) ? r_wbPend : w_feed;
        w_wbBase   = (SBOX_OUT_REG != 0) ? r_wbBase : w_base;
        w_byteMask = '0;
        w_wbData   = '0;
        if (w_wbEn) begin
            for (int k = 0; k < LANES; k++) begin
                w_byteMask[(int'(w_wbBase) + k)*BYTE_W +: BYTE_W] = 8'hff;
                w_wbData[(int'(w_wbBase) + k)*BYTE_W +: BYTE_W]   = w_laneOut[k*8 +: 8];
            end
        end
    end

    // Control FSM, beat counter and in-place state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm    <= ST_IDLE;
            r_cnt    <= '0;
            r_feed   <= 1'b0;
            r_wbPend <= 1'b0;
            r_wbBase <= 4'd0;
            r_state  <= '0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_state <= bus.in_data;
                        r_cnt   <= '0;
                        r_feed  <= 1'b1;
                        r_fsm   <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    r_state  <= (r_state & ~w_byteMask) | w_wbData;
                    r_wbPend <= w_feed;
                    r_wbBase <= w_base;
                    if (w_feed) begin
                        if (w_last) begin
                            r_cnt  <= '0;
                            r_feed <= 1'b0;
                            if (SBOX_OUT_REG == 0) r_fsm <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (r_wbPend) begin
                        r_fsm <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= '0;
                        r_fsm   <= ST_IDLE;
                    end
                end
                default: r_fsm <= ST_IDLE;
            endcase
        end
    end

endmodule
